// File: rtl/ram_dma_controller.sv
// DMA sequencer between SSRAM port B and the system bus, programmed through
// custom instruction 1; transfers are split into bursts with bus release in between.
//
// state       | meaning
// IDLE        | waiting for a start command
// REQ         | requesting the bus until grant is sampled
// BURST_BEGIN | one-cycle busBeginTx with address and burst size
// RD          | bus read beats written into RAM
// PREF        | first RAM address of a write burst presented
// WR          | RAM words streamed onto the bus
// BURST_END   | one-cycle busEndTx after the last write beat
// NEXT        | bus released for a cycle, bus address advanced
module ram_dma_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic [8:0]  ramAddressB,
  output logic        ramWriteEnableB,
  output logic [31:0] ramDataOutB,
  input  logic [31:0] ramDataInB,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        busBeginTx,
  output logic [31:0] busAddress,
  output logic [7:0]  busBurstSize,
  output logic        busReadNotWrite,
  input  logic [31:0] busDataIn,
  input  logic        busDataInValid,
  input  logic        busEndIn,
  output logic [31:0] busDataOut,
  output logic        busDataOutValid,
  input  logic        busBusy,
  output logic        busEndTx,
  input  logic        busError
);

  localparam logic [7:0] customInstructionId = 8'd1;

  typedef enum logic [2:0] {
    IDLE, REQ, BURST_BEGIN, RD, PREF, WR, BURST_END, NEXT
  } stateT;

  stateT state, stateNext;

  logic [31:0] busStartReg;
  logic [8:0]  memStartReg;
  logic [9:0]  blockSizeReg;
  logic [7:0]  burstSizeReg;
  logic        errorReg;
  logic        readMode;

  logic [31:0] busAddr;
  logic [8:0]  memAddr;
  logic [9:0]  remaining;
  logic [8:0]  burstBeats;
  logic [8:0]  beatsLeft;

  logic        isMyCi;
  logic        ciWrite;
  logic [2:0]  ciSel;
  logic        busy;
  logic        startCmd;
  logic        fitsInBurst;
  logic [8:0]  nextBeats;
  logic        rdBeat;
  logic        beatAccept;
  logic        abort;
  logic        unusedBits;

  assign isMyCi     = ciStart & (ciN == customInstructionId);
  assign ciWrite    = isMyCi & ciValueA[9];
  assign ciSel      = ciValueA[12:10];
  assign busy       = (state != IDLE);
  assign abort      = busError & busy;
  assign startCmd   = ciWrite & (ciSel == 3'd5) & (ciValueB[0] | ciValueB[1])
                    & ~busy & (blockSizeReg != 10'd0);
  assign unusedBits = ^{ciValueA[31:13], ciValueA[8:0]};

  // The last burst of a block may be shorter than the programmed burst length.
  assign fitsInBurst = (remaining <= {2'b00, burstSizeReg});
  assign nextBeats   = fitsInBurst ? remaining[8:0] : ({1'b0, burstSizeReg} + 9'd1);

  assign ciDone = isMyCi;

  always_comb begin
    ciResult = 32'd0;
    if (isMyCi) begin
      case (ciSel)
        3'd1:    ciResult = busStartReg;
        3'd2:    ciResult = {23'd0, memStartReg};
        3'd3:    ciResult = {22'd0, blockSizeReg};
        3'd4:    ciResult = {24'd0, burstSizeReg};
        3'd5:    ciResult = {30'd0, errorReg, busy};
        default: ciResult = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busStartReg  <= 32'd0;
      memStartReg  <= 9'd0;
      blockSizeReg <= 10'd0;
      burstSizeReg <= 8'd15;
    end else if (ciWrite && !busy) begin
      case (ciSel)
        3'd1:    busStartReg  <= {ciValueB[31:2], 2'b00};
        3'd2:    memStartReg  <= ciValueB[8:0];
        3'd3:    blockSizeReg <= (ciValueB > 32'd512) ? 10'd512 : ciValueB[9:0];
        3'd4:    burstSizeReg <= ciValueB[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext       = state;
    busRequest      = 1'b0;
    busBeginTx      = 1'b0;
    busAddress      = 32'd0;
    busBurstSize    = 8'd0;
    busReadNotWrite = 1'b0;
    busDataOut      = 32'd0;
    busDataOutValid = 1'b0;
    busEndTx        = 1'b0;
    ramAddressB     = 9'd0;
    ramWriteEnableB = 1'b0;
    ramDataOutB     = 32'd0;
    rdBeat          = 1'b0;
    beatAccept      = 1'b0;
    case (state)
      IDLE: begin
        if (startCmd) stateNext = REQ;
      end
      REQ: begin
        busRequest      = 1'b1;
        busReadNotWrite = readMode;
        if (busGrant) stateNext = BURST_BEGIN;
      end
      BURST_BEGIN: begin
        busRequest      = 1'b1;
        busReadNotWrite = readMode;
        busBeginTx      = 1'b1;
        busAddress      = busAddr;
        busBurstSize    = fitsInBurst ? (remaining[7:0] - 8'd1) : burstSizeReg;
        stateNext       = readMode ? RD : PREF;
      end
      RD: begin
        busRequest      = 1'b1;
        busReadNotWrite = 1'b1;
        ramAddressB     = memAddr;
        if (busDataInValid) begin
          ramWriteEnableB = 1'b1;
          ramDataOutB     = busDataIn;
          rdBeat          = 1'b1;
        end
        if (busEndIn) stateNext = NEXT;
      end
      PREF: begin
        busRequest  = 1'b1;
        ramAddressB = memAddr;
        stateNext   = WR;
      end
      WR: begin
        busRequest      = 1'b1;
        busDataOutValid = 1'b1;
        busDataOut      = ramDataInB;
        beatAccept      = ~busBusy;
        // Look one word ahead on accept so the next beat needs no bubble.
        ramAddressB     = beatAccept ? (memAddr + 9'd1) : memAddr;
        if (beatAccept && (beatsLeft == 9'd1)) stateNext = BURST_END;
      end
      BURST_END: begin
        busRequest = 1'b1;
        busEndTx   = 1'b1;
        stateNext  = NEXT;
      end
      NEXT: begin
        stateNext = (remaining == 10'd0) ? IDLE : REQ;
      end
      default: stateNext = IDLE;
    endcase
    if (abort) stateNext = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      errorReg   <= 1'b0;
      readMode   <= 1'b0;
      busAddr    <= 32'd0;
      memAddr    <= 9'd0;
      remaining  <= 10'd0;
      burstBeats <= 9'd0;
      beatsLeft  <= 9'd0;
    end else begin
      state <= stateNext;
      if (startCmd) begin
        errorReg  <= 1'b0;
        readMode  <= ciValueB[0];
        busAddr   <= busStartReg;
        memAddr   <= memStartReg;
        remaining <= blockSizeReg;
      end
      if (abort) errorReg <= 1'b1;
      if (state == BURST_BEGIN) begin
        burstBeats <= nextBeats;
        beatsLeft  <= nextBeats;
      end
      if (rdBeat || beatAccept) begin
        memAddr   <= memAddr + 9'd1;
        beatsLeft <= beatsLeft - 9'd1;
        if (remaining != 10'd0) remaining <= remaining - 10'd1;
      end
      if (state == NEXT) busAddr <= busAddr + {21'd0, burstBeats, 2'b00};
    end
  end

endmodule

// File: tb/tb_ram_dma_controller.sv
// Directed bench for ram_dma_controller: SSRAM model, reactive bus slave tasks,
// one task per scenario with inline hand-computed expectations.
module tb_ram_dma_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ciStart = 1'b0;
  logic [7:0]  ciN = 8'd0;
  logic [31:0] ciValueA = 32'd0;
  logic [31:0] ciValueB = 32'd0;
  logic        ciDone;
  logic [31:0] ciResult;
  logic [8:0]  ramAddressB;
  logic        ramWriteEnableB;
  logic [31:0] ramDataOutB;
  logic [31:0] ramDataInB;
  logic        busRequest;
  logic        busGrant = 1'b0;
  logic        busBeginTx;
  logic [31:0] busAddress;
  logic [7:0]  busBurstSize;
  logic        busReadNotWrite;
  logic [31:0] busDataIn = 32'd0;
  logic        busDataInValid = 1'b0;
  logic        busEndIn = 1'b0;
  logic [31:0] busDataOut;
  logic        busDataOutValid;
  logic        busBusy = 1'b0;
  logic        busEndTx;
  logic        busError = 1'b0;

  int checks = 0;
  int errors = 0;

  ram_dma_controller dut (
    .clock(clock), .reset(reset),
    .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
    .ciDone(ciDone), .ciResult(ciResult),
    .ramAddressB(ramAddressB), .ramWriteEnableB(ramWriteEnableB),
    .ramDataOutB(ramDataOutB), .ramDataInB(ramDataInB),
    .busRequest(busRequest), .busGrant(busGrant), .busBeginTx(busBeginTx),
    .busAddress(busAddress), .busBurstSize(busBurstSize),
    .busReadNotWrite(busReadNotWrite), .busDataIn(busDataIn),
    .busDataInValid(busDataInValid), .busEndIn(busEndIn),
    .busDataOut(busDataOut), .busDataOutValid(busDataOutValid),
    .busBusy(busBusy), .busEndTx(busEndTx), .busError(busError)
  );

  always #5 clock = ~clock;

  // SSRAM port B model with one-cycle read latency and a bench preload port.
  logic [31:0] ram [0:511];
  logic        preWe = 1'b0;
  logic [8:0]  preAddr = 9'd0;
  logic [31:0] preData = 32'd0;

  always @(posedge clock) begin
    if (preWe) ram[preAddr] <= preData;
    else if (ramWriteEnableB) ram[ramAddressB] <= ramDataOutB;
    ramDataInB <= ram[ramAddressB];
  end

  logic [8:0]  wrAddrQ[$];
  logic [31:0] beginAddrQ[$];
  logic [7:0]  beginSizeQ[$];
  logic [31:0] beatQ[$];
  int          endTxCount = 0;
  int          reqFallCount = 0;
  logic        prevReq = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      if (ramWriteEnableB) wrAddrQ.push_back(ramAddressB);
      if (busBeginTx) begin
        beginAddrQ.push_back(busAddress);
        beginSizeQ.push_back(busBurstSize);
      end
      if (busDataOutValid && !busBusy) beatQ.push_back(busDataOut);
      if (busEndTx) endTxCount++;
      if (prevReq && !busRequest) reqFallCount++;
    end
    prevReq <= busRequest;
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic ciWr(input logic [2:0] sel, input logic [31:0] data);
    ciStart  = 1'b1;
    ciN      = 8'd1;
    ciValueA = {19'd0, sel, 1'b1, 9'd0};
    ciValueB = data;
    step;
    ciStart  = 1'b0;
    ciValueA = 32'd0;
    ciValueB = 32'd0;
  endtask

  task automatic ciRd(input logic [2:0] sel, output logic [31:0] val, output logic done);
    ciStart  = 1'b1;
    ciN      = 8'd1;
    ciValueA = {19'd0, sel, 1'b0, 9'd0};
    ciValueB = 32'd0;
    #1;
    val  = ciResult;
    done = ciDone;
    step;
    ciStart  = 1'b0;
    ciValueA = 32'd0;
  endtask

  task automatic preload(input int base, input int count, input logic [31:0] first);
    for (int i = 0; i < count; i++) begin
      preWe   = 1'b1;
      preAddr = 9'(base + i);
      preData = first + 32'(i);
      step;
    end
    preWe = 1'b0;
  endtask

  // Bus read slave: answers each busBeginTx with busBurstSize+1 consecutive words.
  task automatic serveRead(input logic [31:0] firstData, input int total, input int errBeat,
                           output bit timedOut);
    int served;
    int cyc;
    int left;
    bit inBurst;
    served = 0; cyc = 0; left = 0; inBurst = 0;
    while (served < total && cyc < 400) begin
      step;
      cyc++;
      busDataInValid = 1'b0;
      busEndIn       = 1'b0;
      busError       = 1'b0;
      if (inBurst) begin
        if (served == errBeat) begin
          busError = 1'b1;
          served   = total;
        end else begin
          busDataInValid = 1'b1;
          busDataIn      = firstData + 32'(served);
          served++;
          left--;
          if (left == 0) begin
            busEndIn = 1'b1;
            inBurst  = 0;
          end
        end
      end else if (busBeginTx) begin
        inBurst = 1;
        left    = int'(busBurstSize) + 1;
      end
    end
    timedOut = (served < total);
    step;
    busDataInValid = 1'b0;
    busEndIn       = 1'b0;
    busError       = 1'b0;
  endtask

  // Bus write slave: optionally stalls the beat with index stallAt for stallLen cycles.
  task automatic serveWrite(input int total, input int stallAt, input int stallLen,
                            input logic [31:0] firstWord, output bit timedOut);
    int accepted;
    int cyc;
    int stallLeft;
    accepted = 0; cyc = 0; stallLeft = stallLen;
    while (accepted < total && cyc < 400) begin
      step;
      cyc++;
      busBusy = 1'b0;
      if (busDataOutValid) begin
        if (accepted == stallAt && stallLeft > 0) begin
          busBusy = 1'b1;
          stallLeft--;
          checks++;
          if (busDataOut !== firstWord + 32'(accepted)) begin
            errors++;
            $display("FAIL stall_hold: busDataOut=%h expected %h", busDataOut,
                     firstWord + 32'(accepted));
          end
        end else begin
          accepted++;
        end
      end
    end
    timedOut = (accepted < total);
    step;
    busBusy = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic d;
    reset = 1'b0;
    repeat (3) step;
    checks++;
    if ({busRequest, busBeginTx, busEndTx, busDataOutValid, ramWriteEnableB,
         busReadNotWrite, busAddress, ramAddressB} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b begin=%b addr=%h ramAddr=%h expected all 0",
               busRequest, busBeginTx, busAddress, ramAddressB);
    end
    reset = 1'b1;
    step;
    ciRd(3'd1, v, d);
    checks++;
    if (d !== 1'b1 || v !== 32'd0) begin
      errors++; $display("FAIL reset_busStart: done=%b value=%h expected 1/0", d, v);
    end
    ciRd(3'd3, v, d);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_blockSize: %h expected 0", v); end
    ciRd(3'd4, v, d);
    checks++;
    if (v !== 32'd15) begin errors++; $display("FAIL reset_burstSize: %h expected f", v); end
    ciRd(3'd5, v, d);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_status: %h expected 0", v); end
    ciStart  = 1'b1;
    ciN      = 8'd2;
    ciValueA = {19'd0, 3'd4, 1'b0, 9'd0};
    #1;
    checks++;
    if (ciDone !== 1'b0 || ciResult !== 32'd0) begin
      errors++; $display("FAIL other_ci: done=%b result=%h expected 0/0", ciDone, ciResult);
    end
    step;
    ciStart  = 1'b0;
    ciValueA = 32'd0;
  endtask

  task automatic test_config;
    logic [31:0] v;
    logic d;
    ciWr(3'd3, 32'd1000);
    ciRd(3'd3, v, d);
    checks++;
    if (v !== 32'd512) begin errors++; $display("FAIL clamp_blockSize: %0d expected 512", v); end
    ciWr(3'd1, 32'h0000_1003);
    ciRd(3'd1, v, d);
    checks++;
    if (v !== 32'h0000_1000) begin errors++; $display("FAIL busStart_align: %h expected 1000", v); end
  endtask

  task automatic test_read4;
    logic [31:0] v;
    logic d;
    bit to;
    int b0;
    b0 = beginAddrQ.size();
    busGrant = 1'b1;
    ciWr(3'd2, 32'd10);
    ciWr(3'd3, 32'd4);
    ciWr(3'd4, 32'd15);
    ciWr(3'd5, 32'd1);
    checks++;
    if (busRequest !== 1'b1 || busBeginTx !== 1'b0 || busReadNotWrite !== 1'b1) begin
      errors++;
      $display("FAIL read_req: req=%b begin=%b rnw=%b expected 1/0/1",
               busRequest, busBeginTx, busReadNotWrite);
    end
    serveRead(32'hA0, 4, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL read_timeout: transfer did not complete"); end
    repeat (2) step;
    checks++;
    if (beginAddrQ.size() - b0 != 1 || beginAddrQ[b0] !== 32'h1000 || beginSizeQ[b0] !== 8'd3) begin
      errors++;
      $display("FAIL read_begin: count=%0d addr=%h size=%0d expected 1/1000/3",
               beginAddrQ.size() - b0, beginAddrQ[b0], beginSizeQ[b0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[10 + i] !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL read_ram[%0d]: %h expected %h", 10 + i, ram[10 + i], 32'hA0 + 32'(i));
      end
    end
    ciRd(3'd5, v, d);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL read_done_status: %h expected 0", v); end
  endtask

  task automatic test_write5;
    bit to;
    int b0;
    int q0;
    int e0;
    int r0;
    logic [31:0] expAddr [3];
    logic [7:0]  expSize [3];
    expAddr = '{32'h0, 32'h8, 32'h10};
    expSize = '{8'd1, 8'd1, 8'd0};
    preload(0, 5, 32'hB0);
    ciWr(3'd1, 32'h0);
    ciWr(3'd2, 32'd0);
    ciWr(3'd3, 32'd5);
    ciWr(3'd4, 32'd1);
    b0 = beginAddrQ.size(); q0 = beatQ.size(); e0 = endTxCount; r0 = reqFallCount;
    ciWr(3'd5, 32'd2);
    serveWrite(5, -1, 0, 32'hB0, to);
    checks++;
    if (to) begin errors++; $display("FAIL write_timeout: transfer did not complete"); end
    repeat (3) step;
    checks++;
    if (beginAddrQ.size() - b0 != 3) begin
      errors++; $display("FAIL write_bursts: %0d expected 3", beginAddrQ.size() - b0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (beginAddrQ[b0 + i] !== expAddr[i] || beginSizeQ[b0 + i] !== expSize[i]) begin
          errors++;
          $display("FAIL write_burst%0d: addr=%h size=%0d expected %h/%0d", i,
                   beginAddrQ[b0 + i], beginSizeQ[b0 + i], expAddr[i], expSize[i]);
        end
      end
    end
    checks++;
    if (beatQ.size() - q0 != 5) begin
      errors++; $display("FAIL write_beats: %0d expected 5", beatQ.size() - q0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (beatQ[q0 + i] !== 32'hB0 + 32'(i)) begin
          errors++;
          $display("FAIL write_data%0d: %h expected %h", i, beatQ[q0 + i], 32'hB0 + 32'(i));
        end
      end
    end
    checks++;
    if (endTxCount - e0 != 3 || reqFallCount - r0 != 3) begin
      errors++;
      $display("FAIL write_endtx_release: endTx=%0d releases=%0d expected 3/3",
               endTxCount - e0, reqFallCount - r0);
    end
  endtask

  task automatic test_stall;
    bit to;
    int b0;
    int q0;
    preload(100, 6, 32'hC0);
    ciWr(3'd1, 32'h4000);
    ciWr(3'd2, 32'd100);
    ciWr(3'd3, 32'd6);
    ciWr(3'd4, 32'd15);
    b0 = beginAddrQ.size(); q0 = beatQ.size();
    ciWr(3'd5, 32'd2);
    serveWrite(6, 2, 3, 32'hC0, to);
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: transfer did not complete"); end
    repeat (3) step;
    checks++;
    if (beginAddrQ.size() - b0 != 1 || beginSizeQ[b0] !== 8'd5 || beginAddrQ[b0] !== 32'h4000) begin
      errors++;
      $display("FAIL stall_begin: count=%0d size=%0d addr=%h expected 1/5/4000",
               beginAddrQ.size() - b0, beginSizeQ[b0], beginAddrQ[b0]);
    end
    checks++;
    if (beatQ.size() - q0 != 6) begin
      errors++; $display("FAIL stall_beats: %0d expected 6", beatQ.size() - q0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (beatQ[q0 + i] !== 32'hC0 + 32'(i)) begin
          errors++;
          $display("FAIL stall_data%0d: %h expected %h", i, beatQ[q0 + i], 32'hC0 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_wrap;
    bit to;
    int w0;
    logic [8:0] expA [4];
    expA = '{9'd510, 9'd511, 9'd0, 9'd1};
    ciWr(3'd1, 32'h0);
    ciWr(3'd2, 32'd510);
    ciWr(3'd3, 32'd4);
    w0 = wrAddrQ.size();
    ciWr(3'd5, 32'd1);
    serveRead(32'hD0, 4, -1, to);
    repeat (2) step;
    checks++;
    if (to || wrAddrQ.size() - w0 != 4) begin
      errors++; $display("FAIL wrap_writes: %0d expected 4", wrAddrQ.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wrAddrQ[w0 + i] !== expA[i]) begin
          errors++; $display("FAIL wrap_addr%0d: %0d expected %0d", i, wrAddrQ[w0 + i], expA[i]);
        end
      end
    end
    checks++;
    if (ram[1] !== 32'hD3) begin errors++; $display("FAIL wrap_ram1: %h expected d3", ram[1]); end
  endtask

  task automatic test_zero_block;
    bit sawReq;
    logic [31:0] v;
    logic d;
    ciWr(3'd3, 32'd0);
    ciWr(3'd5, 32'd1);
    sawReq = 0;
    for (int i = 0; i < 3; i++) begin
      if (busRequest !== 1'b0) sawReq = 1;
      step;
    end
    ciRd(3'd5, v, d);
    checks++;
    if (sawReq || v !== 32'd0) begin
      errors++; $display("FAIL zero_block: request=%b status=%h expected 0/0", sawReq, v);
    end
  endtask

  task automatic test_abort_and_reset;
    logic [31:0] v;
    logic d;
    bit to;
    int w0;
    ciWr(3'd1, 32'h2000);
    ciWr(3'd2, 32'd20);
    ciWr(3'd3, 32'd8);
    ciWr(3'd4, 32'd15);
    busGrant = 1'b0;
    ciWr(3'd5, 32'd1);
    repeat (2) step;
    checks++;
    if (busRequest !== 1'b1 || busBeginTx !== 1'b0) begin
      errors++; $display("FAIL grant_wait: req=%b begin=%b expected 1/0", busRequest, busBeginTx);
    end
    ciWr(3'd1, 32'hDEAD_0000);
    ciRd(3'd1, v, d);
    checks++;
    if (v !== 32'h2000) begin errors++; $display("FAIL busy_cfg_write: %h expected 2000", v); end
    ciRd(3'd5, v, d);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL busy_status: %h expected 1", v); end
    w0 = wrAddrQ.size();
    busGrant = 1'b1;
    serveRead(32'hE0, 8, 2, to);
    checks++;
    if (busRequest !== 1'b0 || busBeginTx !== 1'b0 || ramWriteEnableB !== 1'b0) begin
      errors++; $display("FAIL abort_idle: req=%b begin=%b we=%b expected 0/0/0",
                         busRequest, busBeginTx, ramWriteEnableB);
    end
    busDataInValid = 1'b1;
    busDataIn      = 32'hFFFF_FFFF;
    repeat (3) step;
    busDataInValid = 1'b0;
    checks++;
    if (wrAddrQ.size() - w0 != 2 || ram[21] !== 32'hE1) begin
      errors++; $display("FAIL abort_writes: %0d ram21=%h expected 2/e1", wrAddrQ.size() - w0, ram[21]);
    end
    ciRd(3'd5, v, d);
    checks++;
    if (v !== 32'd2) begin errors++; $display("FAIL abort_status: %h expected 2", v); end
    busGrant = 1'b0;
    ciWr(3'd5, 32'd1);
    ciRd(3'd5, v, d);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL restart_status: %h expected 1", v); end
    busGrant = 1'b1;
    repeat (2) step;
    checks++;
    if (busRequest !== 1'b1 || busReadNotWrite !== 1'b1) begin
      errors++; $display("FAIL pre_reset_active: req=%b rnw=%b expected 1/1", busRequest, busReadNotWrite);
    end
    reset = 1'b0;
    step;
    checks++;
    if ({busRequest, busBeginTx, busEndTx, busDataOutValid, ramWriteEnableB,
         busReadNotWrite, busAddress, ramAddressB} !== 47'd0) begin
      errors++; $display("FAIL mid_reset_outputs: req=%b rnw=%b ramAddr=%h expected all 0",
                         busRequest, busReadNotWrite, ramAddressB);
    end
    reset    = 1'b1;
    busGrant = 1'b0;
    ciRd(3'd5, v, d);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_status: %h expected 0", v); end
    ciRd(3'd4, v, d);
    checks++;
    if (v !== 32'd15) begin errors++; $display("FAIL mid_reset_burst: %0d expected 15", v); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_config();
    test_read4();
    test_write5();
    test_stall();
    test_wrap();
    test_zero_block();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
